// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu -- multi-cycle, parametrised-width ALU with valid/ready handshakes.
//
// One operation is in flight at a time. Logic/add/compare/find-first-one
// results are computed at the accepting edge. Shifts step one bit per cycle.
// Unsigned multiply (shift-add) and unsigned restoring divide each take N
// iterations. The result registers also serve as the working registers
// while the unit is BUSY.
//
// Ports
//   clk, rst_n            : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   : request handshake (in_ready=1 only in IDLE)
//   A, B, Cin, Mode       : operands, carry-in (ADD only), operation select
//   out_valid / out_ready : result handshake (out_valid=1 only in DONE)
//   Y, Yh                 : primary / secondary result (MUL high, DIV rem)
//   Cout, Overflow, Zero, DivZero : result flags
// ---------------------------------------------------------------------------
module seq_alu #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic [3:0]   Mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Y,
  output logic [N-1:0] Yh,
  output logic         Cout,
  output logic         Overflow,
  output logic         Zero,
  output logic         DivZero
);

  localparam int S = $clog2(N);

  localparam logic [3:0] M_SLL  = 4'd0;
  localparam logic [3:0] M_SLA  = 4'd1;
  localparam logic [3:0] M_SRL  = 4'd2;
  localparam logic [3:0] M_SRA  = 4'd3;
  localparam logic [3:0] M_ADD  = 4'd4;
  localparam logic [3:0] M_SUB  = 4'd5;
  localparam logic [3:0] M_AND  = 4'd6;
  localparam logic [3:0] M_OR   = 4'd7;
  localparam logic [3:0] M_NOT  = 4'd8;
  localparam logic [3:0] M_XOR  = 4'd9;
  localparam logic [3:0] M_XNOR = 4'd10;
  localparam logic [3:0] M_NOR  = 4'd11;
  localparam logic [3:0] M_MULU = 4'd12;
  localparam logic [3:0] M_DIVU = 4'd13;
  localparam logic [3:0] M_CMP  = 4'd14;
  localparam logic [3:0] M_FFO  = 4'd15;

  localparam logic [S:0] CNT_ZERO = {(S+1){1'b0}};
  localparam logic [S:0] CNT_ONE  = {{S{1'b0}}, 1'b1};
  localparam logic [S:0] CNT_N    = (S+1)'(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [3:0]   mode_q, mode_d;
  logic [S:0]   cnt_q, cnt_d;
  logic [N-1:0] y_q, y_d;
  logic [N-1:0] yh_q, yh_d;
  logic         cout_q, cout_d;
  logic         ovf_q, ovf_d;
  logic         zero_q, zero_d;
  logic         divz_q, divz_d;

  logic         finish_s;
  logic [N:0]   add_s;
  logic [N:0]   mul_sum_s;
  logic [N:0]   div_trial_s;
  logic [N-1:0] div_diff_s;

  // Index of the most-significant set bit; 0 when no bit is set.
  function automatic logic [S-1:0] ffo_idx(input logic [N-1:0] v);
    logic [S-1:0] idx;
    idx = {S{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        idx = i[S-1:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Next-state, datapath step and flag computation.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    y_d         = y_q;
    yh_d        = yh_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    divz_d      = divz_q;
    finish_s    = 1'b0;
    add_s       = {(N+1){1'b0}};
    mul_sum_s   = {(N+1){1'b0}};
    div_trial_s = {(N+1){1'b0}};
    div_diff_s  = {N{1'b0}};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Cin only matters to ADD, which completes here, so it is
          // consumed at acceptance rather than held.
          a_d      = A;
          b_d      = B;
          mode_d   = Mode;
          cnt_d    = CNT_ZERO;
          yh_d     = {N{1'b0}};
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          divz_d   = 1'b0;
          state_d  = DONE;
          finish_s = 1'b1;
          case (Mode)
            M_SLL, M_SLA, M_SRL, M_SRA: begin
              y_d   = A;
              cnt_d = {1'b0, B[S-1:0]};
              if (B[S-1:0] != {S{1'b0}}) begin
                state_d  = BUSY;
                finish_s = 1'b0;
              end else begin
                state_d  = DONE;
              end
            end
            M_ADD: begin
              add_s  = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, Cin};
              y_d    = add_s[N-1:0];
              cout_d = add_s[N];
              ovf_d  = (A[N-1] == B[N-1]) && (add_s[N-1] != A[N-1]);
            end
            M_SUB: begin
              add_s  = {1'b0, A} + {1'b0, ~B} + {{N{1'b0}}, 1'b1};
              y_d    = add_s[N-1:0];
              cout_d = add_s[N];
              ovf_d  = (A[N-1] != B[N-1]) && (add_s[N-1] != A[N-1]);
            end
            M_AND:  y_d = A & B;
            M_OR:   y_d = A | B;
            M_NOT:  y_d = ~A;
            M_XOR:  y_d = A ^ B;
            M_XNOR: y_d = ~(A ^ B);
            M_NOR:  y_d = ~(A | B);
            M_MULU: begin
              // {yh, y} is the product/multiplier pair of shift-add.
              y_d      = B;
              cnt_d    = CNT_N;
              state_d  = BUSY;
              finish_s = 1'b0;
            end
            M_DIVU: begin
              if (B == {N{1'b0}}) begin
                y_d    = {N{1'b1}};
                yh_d   = A;
                divz_d = 1'b1;
              end else begin
                // y holds the dividend shifting out / quotient shifting in.
                y_d      = A;
                cnt_d    = CNT_N;
                state_d  = BUSY;
                finish_s = 1'b0;
              end
            end
            M_CMP:   y_d = {{(N-1){1'b0}}, ($signed(A) < $signed(B))};
            M_FFO:   y_d = {{(N-S){1'b0}}, ffo_idx(A)};
            default: y_d = {N{1'b0}};
          endcase
        end else begin
          state_d = IDLE;
        end
      end

      BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d  = DONE;
          finish_s = 1'b1;
        end else begin
          state_d  = BUSY;
        end
        case (mode_q)
          M_SLL: y_d = {y_q[N-2:0], 1'b0};
          M_SLA: begin
            y_d   = {y_q[N-2:0], 1'b0};
            // Sign changes on this step when the two top bits differ.
            ovf_d = ovf_q | (y_q[N-1] ^ y_q[N-2]);
          end
          M_SRL: y_d = {1'b0, y_q[N-1:1]};
          M_SRA: y_d = {y_q[N-1], y_q[N-1:1]};
          M_MULU: begin
            if (y_q[0]) begin
              mul_sum_s = {1'b0, yh_q} + {1'b0, a_q};
            end else begin
              mul_sum_s = {1'b0, yh_q};
            end
            yh_d = mul_sum_s[N:1];
            y_d  = {mul_sum_s[0], y_q[N-1:1]};
          end
          M_DIVU: begin
            // Partial remainder can reach 2B-1, hence the extra bit.
            div_trial_s = {yh_q, y_q[N-1]};
            div_diff_s  = div_trial_s[N-1:0] - b_q;
            if (div_trial_s >= {1'b0, b_q}) begin
              yh_d = div_diff_s;
              y_d  = {y_q[N-2:0], 1'b1};
            end else begin
              yh_d = div_trial_s[N-1:0];
              y_d  = {y_q[N-2:0], 1'b0};
            end
          end
          default: y_d = y_q;
        endcase
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Zero is evaluated only when a result is finalised so it stays
    // consistent with Y while held in DONE.
    if (finish_s) begin
      zero_d = (y_d == {N{1'b0}});
    end else begin
      zero_d = zero_q;
    end
  end

  // State, operand, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= {N{1'b0}};
      b_q     <= {N{1'b0}};
      mode_q  <= 4'd0;
      cnt_q   <= CNT_ZERO;
      y_q     <= {N{1'b0}};
      yh_q    <= {N{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      yh_q    <= yh_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      divz_q  <= divz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Y         = y_q;
  assign Yh        = yh_q;
  assign Cout      = cout_q;
  assign Overflow  = ovf_q;
  assign Zero      = zero_q;
  assign DivZero   = divz_q;

endmodule

// File: tb/tb_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_seq_alu -- directed self-checking bench for seq_alu (N=16).
// Result word compared per op: {Y, Yh, Cout, Overflow, Zero, DivZero}.
// Latency = negedges counted after the accepting posedge until out_valid=1.
// ---------------------------------------------------------------------------
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = 16'h0000;
  logic [15:0] B = 16'h0000;
  logic        Cin = 1'b0;
  logic [3:0]  Mode = 4'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] Y;
  logic [15:0] Yh;
  logic        Cout, Overflow, Zero, DivZero;

  int nvec = 0;
  int nerr = 0;

  typedef struct packed {
    logic [3:0]  m;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [35:0] exp;
    logic [7:0]  lat;
  } vec_t;

  seq_alu #(.N(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .Mode(Mode), .out_valid(out_valid),
    .out_ready(out_ready), .Y(Y), .Yh(Yh), .Cout(Cout), .Overflow(Overflow),
    .Zero(Zero), .DivZero(DivZero)
  );

  always #5 clk = ~clk;

  // Issue one request, scramble inputs after acceptance, wait for result.
  task automatic do_op(input logic [3:0] m, input logic [15:0] a,
                       input logic [15:0] b, input logic c, output int lat);
    @(negedge clk);
    Mode = m; A = a; B = b; Cin = c; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; Mode = ~m; A = ~a; B = ~b; Cin = ~c;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    nvec++;
    if ({in_ready, out_valid, Y, Yh, Cout, Overflow, Zero, DivZero} !== {2'b10, 36'h0}) begin
      nerr++;
      $display("FAIL reset_state: got rdy=%b vld=%b Y=%h Yh=%h flags=%b%b%b%b want rdy=1 vld=0 all 0",
               in_ready, out_valid, Y, Yh, Cout, Overflow, Zero, DivZero);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    vec_t tv[13];
    int   lat;
    tv = '{
      '{4'd4,  16'h7FFF, 16'h0001, 1'b0, {16'h8000, 16'h0000, 4'b0100}, 8'd1},
      '{4'd5,  16'h0005, 16'h0005, 1'b0, {16'h0000, 16'h0000, 4'b1010}, 8'd1},
      '{4'd4,  16'hFFFF, 16'h0000, 1'b1, {16'h0000, 16'h0000, 4'b1010}, 8'd1},
      '{4'd4,  16'h0001, 16'h0001, 1'b1, {16'h0003, 16'h0000, 4'b0000}, 8'd1},
      '{4'd5,  16'h8000, 16'h0001, 1'b0, {16'h7FFF, 16'h0000, 4'b1100}, 8'd1},
      '{4'd6,  16'hF0F0, 16'h3C3C, 1'b0, {16'h3030, 16'h0000, 4'b0000}, 8'd1},
      '{4'd7,  16'hF0F0, 16'h3C3C, 1'b0, {16'hFCFC, 16'h0000, 4'b0000}, 8'd1},
      '{4'd8,  16'hF0F0, 16'h3C3C, 1'b0, {16'h0F0F, 16'h0000, 4'b0000}, 8'd1},
      '{4'd9,  16'hF0F0, 16'h3C3C, 1'b0, {16'hCCCC, 16'h0000, 4'b0000}, 8'd1},
      '{4'd10, 16'hF0F0, 16'h3C3C, 1'b0, {16'h3333, 16'h0000, 4'b0000}, 8'd1},
      '{4'd11, 16'hF0F0, 16'h3C3C, 1'b0, {16'h0303, 16'h0000, 4'b0000}, 8'd1},
      '{4'd14, 16'hFFFF, 16'h0001, 1'b0, {16'h0001, 16'h0000, 4'b0000}, 8'd1},
      '{4'd14, 16'h0001, 16'hFFFF, 1'b0, {16'h0000, 16'h0000, 4'b0010}, 8'd1}
    };
    foreach (tv[i]) begin
      do_op(tv[i].m, tv[i].a, tv[i].b, tv[i].c, lat);
      nvec++;
      if ({Y, Yh, Cout, Overflow, Zero, DivZero} !== tv[i].exp || lat != int'(tv[i].lat)) begin
        nerr++;
        $display("FAIL single[%0d]: got res=%h lat=%0d want res=%h lat=%0d",
                 i, {Y, Yh, Cout, Overflow, Zero, DivZero}, lat, tv[i].exp, tv[i].lat);
      end
      release_out();
    end
  endtask

  task automatic test_shift();
    vec_t tv[11];
    int   lat;
    tv = '{
      '{4'd3, 16'h8010, 16'h0004, 1'b0, {16'hF801, 16'h0000, 4'b0000}, 8'd5},
      '{4'd1, 16'h2000, 16'h0002, 1'b0, {16'h8000, 16'h0000, 4'b0100}, 8'd3},
      '{4'd0, 16'h1234, 16'hFFF0, 1'b0, {16'h1234, 16'h0000, 4'b0000}, 8'd1},
      '{4'd3, 16'h8000, 16'h000F, 1'b0, {16'hFFFF, 16'h0000, 4'b0000}, 8'd16},
      '{4'd2, 16'h8000, 16'h0013, 1'b0, {16'h1000, 16'h0000, 4'b0000}, 8'd4},
      '{4'd0, 16'h0001, 16'h0010, 1'b0, {16'h0001, 16'h0000, 4'b0000}, 8'd1},
      '{4'd1, 16'h4000, 16'h0001, 1'b0, {16'h8000, 16'h0000, 4'b0100}, 8'd2},
      '{4'd1, 16'hC000, 16'h0001, 1'b0, {16'h8000, 16'h0000, 4'b0000}, 8'd2},
      '{4'd1, 16'h0003, 16'h0002, 1'b0, {16'h000C, 16'h0000, 4'b0000}, 8'd3},
      '{4'd0, 16'h8000, 16'h0001, 1'b0, {16'h0000, 16'h0000, 4'b0010}, 8'd2},
      '{4'd2, 16'hFFFF, 16'h000F, 1'b0, {16'h0001, 16'h0000, 4'b0000}, 8'd16}
    };
    foreach (tv[i]) begin
      do_op(tv[i].m, tv[i].a, tv[i].b, tv[i].c, lat);
      nvec++;
      if ({Y, Yh, Cout, Overflow, Zero, DivZero} !== tv[i].exp || lat != int'(tv[i].lat)) begin
        nerr++;
        $display("FAIL shift[%0d]: got res=%h lat=%0d want res=%h lat=%0d",
                 i, {Y, Yh, Cout, Overflow, Zero, DivZero}, lat, tv[i].exp, tv[i].lat);
      end
      release_out();
    end
  endtask

  task automatic test_mul_div();
    vec_t tv[10];
    int   lat;
    tv = '{
      '{4'd12, 16'hFFFF, 16'hFFFF, 1'b0, {16'h0001, 16'hFFFE, 4'b0000}, 8'd17},
      '{4'd12, 16'h0003, 16'h0005, 1'b0, {16'h000F, 16'h0000, 4'b0000}, 8'd17},
      '{4'd12, 16'h1234, 16'h0000, 1'b0, {16'h0000, 16'h0000, 4'b0010}, 8'd17},
      '{4'd12, 16'h0100, 16'h0100, 1'b0, {16'h0000, 16'h0001, 4'b0010}, 8'd17},
      '{4'd13, 16'd100,  16'd7,    1'b0, {16'd14,   16'd2,    4'b0000}, 8'd17},
      '{4'd13, 16'd9,    16'd0,    1'b0, {16'hFFFF, 16'd9,    4'b0001}, 8'd1},
      '{4'd13, 16'hFFFF, 16'h0001, 1'b0, {16'hFFFF, 16'h0000, 4'b0000}, 8'd17},
      '{4'd13, 16'h0003, 16'h0005, 1'b0, {16'h0000, 16'h0003, 4'b0010}, 8'd17},
      '{4'd13, 16'hFFFF, 16'hFFFF, 1'b0, {16'h0001, 16'h0000, 4'b0000}, 8'd17},
      '{4'd13, 16'h8000, 16'h0003, 1'b0, {16'h2AAA, 16'h0002, 4'b0000}, 8'd17}
    };
    foreach (tv[i]) begin
      do_op(tv[i].m, tv[i].a, tv[i].b, tv[i].c, lat);
      nvec++;
      if ({Y, Yh, Cout, Overflow, Zero, DivZero} !== tv[i].exp || lat != int'(tv[i].lat)) begin
        nerr++;
        $display("FAIL muldiv[%0d]: got res=%h lat=%0d want res=%h lat=%0d",
                 i, {Y, Yh, Cout, Overflow, Zero, DivZero}, lat, tv[i].exp, tv[i].lat);
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    do_op(4'd12, 16'h0003, 16'h0005, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      nvec++;
      if ({in_ready, out_valid, Y, Yh, Cout, Overflow, Zero, DivZero} !== {2'b01, 16'h000F, 16'h0000, 4'b0000}) begin
        nerr++;
        $display("FAIL hold[%0d]: got rdy=%b vld=%b Y=%h Yh=%h want rdy=0 vld=1 Y=000f Yh=0000",
                 i, in_ready, out_valid, Y, Yh);
      end
      @(negedge clk);
    end
    release_out();
    nvec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      nerr++;
      $display("FAIL hold_release: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_busy();
    int lat;
    @(negedge clk);
    Mode = 4'd13; A = 16'd100; B = 16'd7; in_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      Mode = 4'd4; A = 16'h1111; B = 16'h2222; in_valid = 1'b1;
      nvec++;
      if (in_ready !== 1'b0) begin
        nerr++;
        $display("FAIL busy_rdy[%0d]: got in_ready=%b want 0", i, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    nvec++;
    if ({out_valid, Y, Yh, DivZero} !== {1'b1, 16'd14, 16'd2, 1'b0}) begin
      nerr++;
      $display("FAIL busy_ignore: got vld=%b Y=%h Yh=%h want vld=1 Y=000e Yh=0002", out_valid, Y, Yh);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    @(negedge clk);
    Mode = 4'd4; A = 16'd1; B = 16'd2; Cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    A = 16'd3; B = 16'd4;
    nvec++;
    if ({in_ready, out_valid, Y} !== {2'b01, 16'd3}) begin
      nerr++;
      $display("FAIL b2b_first: got rdy=%b vld=%b Y=%h want rdy=0 vld=1 Y=0003", in_ready, out_valid, Y);
    end
    @(negedge clk);
    nvec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      nerr++;
      $display("FAIL b2b_gap: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    nvec++;
    if ({in_ready, out_valid, Y} !== {2'b01, 16'd7}) begin
      nerr++;
      $display("FAIL b2b_second: got rdy=%b vld=%b Y=%h want rdy=0 vld=1 Y=0007", in_ready, out_valid, Y);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    Mode = 4'd12; A = 16'hFFFF; B = 16'hFFFF; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if ({in_ready, out_valid, Y, Yh, Cout, Overflow, Zero, DivZero} !== {2'b10, 36'h0}) begin
      nerr++;
      $display("FAIL reset_mid: got rdy=%b vld=%b Y=%h Yh=%h want rdy=1 vld=0 all 0",
               in_ready, out_valid, Y, Yh);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nvec++;
      if (out_valid !== 1'b0) begin
        nerr++;
        $display("FAIL reset_mid_vld[%0d]: got %b want 0", i, out_valid);
      end
    end
    rst_n = 1'b1;
    do_op(4'd15, 16'h0400, 16'h0000, 1'b0, lat);
    nvec++;
    if ({Y, Zero, lat} !== {16'd10, 1'b0, 32'd1}) begin
      nerr++;
      $display("FAIL ffo_0400: got Y=%h Z=%b lat=%0d want Y=000a Z=0 lat=1", Y, Zero, lat);
    end
    release_out();
    do_op(4'd15, 16'h0000, 16'h0000, 1'b0, lat);
    nvec++;
    if ({Y, Zero} !== {16'd0, 1'b1}) begin
      nerr++;
      $display("FAIL ffo_zero: got Y=%h Z=%b want Y=0000 Z=1", Y, Zero);
    end
    release_out();
    do_op(4'd15, 16'h8001, 16'h0000, 1'b0, lat);
    nvec++;
    if ({Y, Zero} !== {16'd15, 1'b0}) begin
      nerr++;
      $display("FAIL ffo_8001: got Y=%h Z=%b want Y=000f Z=0", Y, Zero);
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_single();
    test_shift();
    test_mul_div();
    test_backpressure();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle, parametrised-width arithmetic/logic unit with valid/ready handshakes on both sides. It extends the lab's 16-bit combinational ALU in four ways:
- operand width is a parameter;
- shifts take a variable amount;
- iterative multiply and divide are added;
- results are registered.

It sits between an operand-issue stage and a writeback stage. One operation is in flight at a time.

## Interface
- `N`, 16, operand/result width (≥4, power of two)
- `S`, `$clog2(N)`, shift-amount width (derived, not overridden)
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operation request
- `in_ready`  out  1  unit can accept a request
- `A`, `B`  in  N  operands, signed or unsigned per mode
- `Cin`  in  1  carry-in (ADD only)
- `Mode`  in  4  operation select
- `out_valid`  out  1  result available
- `out_ready`  in  1  downstream accepts result
- `Y`  out  N  primary result
- `Yh`  out  N  secondary result (MUL high half, DIVU remainder, else 0)
- `Cout`, `Overflow`, `Zero`, `DivZero`  out  1 each  result flags

## Operation
- **Modes**
  - 0 SLL by `B[S-1:0]`
  - 1 SLA by `B[S-1:0]`: same bits as SLL; `Overflow`=1 if the sign bit changes at any step
  - 2 SRL by `B[S-1:0]`
  - 3 SRA by `B[S-1:0]`
  - 4 ADD: `A+B+Cin`; `Cout` is the carry out of bit N-1; `Overflow` is signed overflow
  - 5 SUB: `A+~B+1`; `Cout`=1 means no borrow; `Overflow` is signed overflow
  - 6 AND, 7 OR, 8 NOT A, 9 XOR, 10 XNOR, 11 NOR
  - 12 MULU: unsigned `A*B`; `Y` is the low N bits, `Yh` the high N bits
  - 13 DIVU: `Y`=A/B, `Yh`=A%B, unsigned restoring division
  - 14 CMP: `Y`=1 if signed A<B, else 0
  - 15 FFO: `Y`=index of the most-significant 1 in A
- **Flags**
  - `Cout`/`Overflow` are 0 for every mode not listed above as setting them.
  - `Zero`=(Y==0) for all modes.
  - `DivZero` is set only for DIVU with B=0.
- **FSM:** IDLE → BUSY → DONE → IDLE.
  - IDLE: `in_ready`=1. On `in_valid&&in_ready`, latch A, B, Cin and Mode.
    - Single-cycle modes (4–11, 14, 15): go directly to DONE.
    - Otherwise: go to BUSY.
    - DIVU with B=0: go directly to DONE with `Y`=all ones, `Yh`=A, `DivZero`=1.
  - BUSY:
    - Shifts move one bit per cycle for k=`B[S-1:0]` cycles; k=0 skips BUSY.
    - MULU (shift-add) and DIVU each spend exactly N cycles.
    - An internal counter of width S+1 tracks progress.
  - DONE: `out_valid`=1 and all outputs are held stable until `out_ready`=1, then return to IDLE.
- **Operand stability:** inputs changed after acceptance are ignored. Requests in BUSY or DONE are not accepted (`in_ready`=0).

## Timing
- Reset (async assert, synchronous deassert by the surrounding logic):
  - state=IDLE
  - `in_ready`=1
  - `out_valid`=0
  - `Y`=`Yh`=0
  - all flags=0
  - counter=0
- Latency, counted from the accepting edge to the edge where `out_valid` is asserted:
  - single-cycle ops: 1 cycle
  - shifts: 1+k cycles
  - MULU/DIVU: 1+N cycles
  - DIVU with B=0: 1 cycle
- Throughput: the minimum request spacing is latency+1 cycles when `out_ready` is held high. `in_ready` rises on the cycle after the output handshake; there is no overlap of result and accept.
- Back-pressure: while `out_ready`=0 in DONE, `out_valid`, `Y`, `Yh` and the flags do not change.
- Reset asserted in BUSY or DONE aborts the operation. No `out_valid` is produced for it, and `in_ready`=1 immediately.
- Shift amount: only `B[S-1:0]` is used and upper B bits are ignored. A shift by N-1 completes with the correct value (e.g. SRA of a negative value gives all ones).

## Test plan
- **Reset and single-cycle ops.** Reset; then ADD A=16'h7FFF, B=1, Cin=0 → one cycle later `out_valid`; `Y`=16'h8000, `Overflow`=1, `Cout`=0, `Zero`=0. Then SUB A=5, B=5 → `Y`=0, `Zero`=1, `Cout`=1.
- **Variable shifts.** SRA A=16'h8010, B=4 → `out_valid` 5 cycles after accept with `Y`=16'hF801. SLA A=16'h2000, B=2 → `Y`=16'h8000, `Overflow`=1. Shift with B=0 → 1-cycle latency, `Y`=A.
- **Multiply.** MULU A=16'hFFFF, B=16'hFFFF → `out_valid` exactly 17 cycles after accept with `Yh`=16'hFFFE, `Y`=16'h0001.
- **Divide.** DIVU A=100, B=7 → after 17 cycles `Y`=14, `Yh`=2, `DivZero`=0. DIVU A=9, B=0 → after 1 cycle `Y`=16'hFFFF, `Yh`=9, `DivZero`=1.
- **Back-pressure and busy.**
  - Hold `out_ready`=0 for 5 cycles in DONE → outputs stable.
  - Pulse `in_valid` with new operands during BUSY → `in_ready`=0, request ignored, original result unchanged.
- **Reset mid-operation.** Assert `rst_n`=0 during MULU BUSY → `out_valid` stays 0 and all outputs return to 0. After release, FFO A=16'h0400 → `Y`=10; FFO A=0 → `Y`=0, `Zero`=1.
